// File: rtl/stack_pkg.sv
// Shared types and default sizes for the LIFO stack controller.
package stack_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 256;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_READ    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;
endpackage

// File: rtl/stack_pointer.sv
// Stack entry counter with empty/full decode and top-entry address.
module stack_pointer
  import stack_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  i_inc,
  input  logic                  i_dec,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [ADDR_WIDTH-1:0] o_top_addr
);

  logic [ADDR_WIDTH:0] r_count;

  // Count register: increments on push, decrements on pop, otherwise holds.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_count <= '0;
    end else if (i_inc && !i_dec) begin
      r_count <= r_count + (ADDR_WIDTH+1)'(1);
    end else if (i_dec && !i_inc) begin
      r_count <= r_count - (ADDR_WIDTH+1)'(1);
    end
  end

  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (ADDR_WIDTH+1)'(DEPTH));
  // Low bits only: at Count==DEPTH this is DEPTH-1, the last written entry.
  assign o_top_addr = r_count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

endmodule

// File: rtl/stack_controller.sv
// LIFO stack sequencer for a single-port RAM with registered read data.
// Optional macro STACK_ERROR_FLAG_EN: sticky overflow/underflow Error flag.
//
// state   | meaning
// IDLE    | accepting push/pop, RAM idle
// WRITE   | writing Top to RAM at Count-1
// READ    | reading new top entry at Count-1
// CAPTURE | RAM data valid, load into Top
module stack_controller
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  Push,
  input  logic                  Pop,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic [DATA_WIDTH-1:0] RamDataOut,
  output logic                  RamEnable,
  output logic                  RamWriteEnable,
  output logic [ADDR_WIDTH-1:0] RamAddress,
  output logic [DATA_WIDTH-1:0] RamDataIn,
  output logic [DATA_WIDTH-1:0] Top,
  output logic                  TopValid,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Empty,
  output logic                  Full,
  output logic                  Ready,
  output logic                  Error
);

  state_t                r_state, w_next_state;
  logic [DATA_WIDTH-1:0] r_top;
  logic                  r_top_valid;
  logic                  w_inc, w_dec, w_load_in, w_capture, w_clear_valid;
  logic [ADDR_WIDTH-1:0] w_top_addr;
  logic                  w_last;

  stack_pointer #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_ptr (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .i_inc      (w_inc),
    .i_dec      (w_dec),
    .o_count    (Count),
    .o_empty    (Empty),
    .o_full     (Full),
    .o_top_addr (w_top_addr)
  );

  assign w_last = (Count == (ADDR_WIDTH+1)'(1));

  // State register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state and datapath controls; Push+Pop on an empty stack is a plain push.
  always_comb begin
    w_next_state  = r_state;
    w_inc         = 1'b0;
    w_dec         = 1'b0;
    w_load_in     = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Push && (!Pop || Empty)) begin
          if (!Full) begin
            w_load_in    = 1'b1;
            w_inc        = 1'b1;
            w_next_state = S_WRITE;
          end
        end else if (Push && Pop) begin
          w_load_in    = 1'b1;
          w_next_state = S_WRITE;
        end else if (Pop && !Empty) begin
          w_dec = 1'b1;
          if (w_last) w_clear_valid = 1'b1;
          else        w_next_state  = S_READ;
        end
      end
      S_WRITE:   w_next_state = S_IDLE;
      S_READ:    w_next_state = S_CAPTURE;
      S_CAPTURE: begin
        w_capture    = 1'b1;
        w_next_state = S_IDLE;
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  // RAM strobes and Ready decoded from the current state.
  always_comb begin
    Ready          = 1'b0;
    RamEnable      = 1'b0;
    RamWriteEnable = 1'b0;
    RamAddress     = '0;
    RamDataIn      = '0;
    case (r_state)
      S_IDLE:  Ready = 1'b1;
      S_WRITE: begin
        RamEnable      = 1'b1;
        RamWriteEnable = 1'b1;
        RamAddress     = w_top_addr;
        RamDataIn      = r_top;
      end
      S_READ: begin
        RamEnable  = 1'b1;
        RamAddress = w_top_addr;
      end
      default: ;
    endcase
  end

  // Top-of-stack register and its valid flag.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_top       <= '0;
      r_top_valid <= 1'b0;
    end else if (w_load_in) begin
      r_top       <= DataIn;
      r_top_valid <= 1'b1;
    end else if (w_capture) begin
      r_top       <= RamDataOut;
      r_top_valid <= 1'b1;
    end else if (w_clear_valid) begin
      r_top_valid <= 1'b0;
    end
  end

  assign Top      = r_top;
  assign TopValid = r_top_valid;

`ifdef STACK_ERROR_FLAG_EN
  logic r_error;
  logic w_err_event;

  assign w_err_event = (r_state == S_IDLE) &&
                       ((Push && !Pop && Full) || (Pop && !Push && Empty));

  // Sticky error: set on any overflow or underflow, cleared only by reset.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)          r_error <= 1'b0;
    else if (w_err_event) r_error <= 1'b1;
  end

  assign Error = r_error;
`else
  assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a behavioural single-port RAM.
module tb_stack_controller;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  logic       Push = 1'b0, Pop = 1'b0;
  logic [7:0] DataIn = '0;
  logic [7:0] RamDataOut;
  logic       RamEnable, RamWriteEnable;
  logic [7:0] RamAddress, RamDataIn, Top;
  logic       TopValid, Empty, Full, Ready, Error;
  logic [8:0] Count;

  int checks = 0;
  int errors = 0;

`ifdef STACK_ERROR_FLAG_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  stack_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256)) dut (
    .Clk(Clk), .ResetN(ResetN), .Push(Push), .Pop(Pop), .DataIn(DataIn),
    .RamDataOut(RamDataOut), .RamEnable(RamEnable), .RamWriteEnable(RamWriteEnable),
    .RamAddress(RamAddress), .RamDataIn(RamDataIn), .Top(Top), .TopValid(TopValid),
    .Count(Count), .Empty(Empty), .Full(Full), .Ready(Ready), .Error(Error)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem [256];
  logic [7:0] r_rdata = '0;
  assign RamDataOut = r_rdata;

  always @(posedge Clk) begin
    if (RamEnable) begin
      if (RamWriteEnable) mem[RamAddress] <= RamDataIn;
      else                r_rdata <= mem[RamAddress];
    end
  end

  typedef struct {
    logic       push, pop;
    logic [7:0] din;
    logic       ready;
    logic [7:0] top;
    logic [8:0] cnt;
    logic       valid, en, we;
    logic [7:0] addr, rdin;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [7:0] d);
    @(negedge Clk);
    Push = p; Pop = q; DataIn = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    chk(name, 64'({Count, Empty, Full, Ready, TopValid, Error, Top,
                   RamEnable, RamWriteEnable, RamAddress, RamDataIn}),
        64'({9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    //            push  pop   din    ready top    cnt    valid en    we    addr   rdin
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h11, 9'd1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h11};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 9'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h22, 9'd2, 1'b1, 1'b1, 1'b1, 8'h01, 8'h22};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 9'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 8'h33, 1'b0, 8'h33, 9'd3, 1'b1, 1'b1, 1'b1, 8'h02, 8'h33};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 9'd3, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h33, 9'd2, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h33, 9'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 9'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 8'h77, 1'b0, 8'h77, 9'd2, 1'b1, 1'b1, 1'b1, 8'h01, 8'h77};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 9'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h77, 9'd1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h77, 9'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 9'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h11, 9'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[15] = '{1'b1, 1'b0, 8'hAA, 1'b0, 8'hAA, 9'd1, 1'b1, 1'b1, 1'b1, 8'h00, 8'hAA};
    vecs[16] = '{1'b1, 1'b0, 8'hBB, 1'b1, 8'hAA, 9'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};

    #12;
    check_reset("reset_initial");
    @(negedge Clk);
    ResetN = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din);
      chk($sformatf("vec%0d", i),
          64'({Ready, Top, Count, TopValid, RamEnable, RamWriteEnable, RamAddress, RamDataIn}),
          64'({vecs[i].ready, vecs[i].top, vecs[i].cnt, vecs[i].valid,
               vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].rdin}));
    end
    step(1'b0, 1'b0, 8'h00);
    chk("ram1_replaced", 64'(mem[1]), 64'h77);
    chk("ram2_written", 64'(mem[2]), 64'h33);
    chk("no_error_legal_ops", 64'(Error), 64'h0);

    // Mid-run asynchronous reset.
    @(negedge Clk);
    ResetN = 1'b0;
    #1;
    check_reset("reset_midrun");
    @(negedge Clk);
    ResetN = 1'b1;

    // Fill to capacity.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, 8'(i));
      step(1'b0, 1'b0, 8'h00);
    end
    chk("full_state", 64'({Full, Empty, Count, Top, TopValid, Error}),
        64'({1'b1, 1'b0, 9'd256, 8'hFF, 1'b1, 1'b0}));
    chk("ram255_written", 64'(mem[255]), 64'hFF);
    chk("ram0_written", 64'(mem[0]), 64'h00);
    step(1'b1, 1'b0, 8'hAA);
    chk("overflow_ignored", 64'({Ready, Count, Top, RamEnable, Error}),
        64'({1'b1, 9'd256, 8'hFF, 1'b0, EXP_ERR}));
    step(1'b0, 1'b0, 8'h00);
    chk("overflow_sticky", 64'({Count, Error}), 64'({9'd256, EXP_ERR}));

    // Underflow after reset.
    @(negedge Clk);
    ResetN = 1'b0;
    #1;
    check_reset("reset_when_full");
    @(negedge Clk);
    ResetN = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    chk("underflow_ignored", 64'({Ready, Count, Empty, TopValid, RamEnable, Error}),
        64'({1'b1, 9'd0, 1'b1, 1'b0, 1'b0, EXP_ERR}));

    // Reset while in READ.
    @(negedge Clk);
    ResetN = 1'b0;
    @(negedge Clk);
    ResetN = 1'b1;
    step(1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h02);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("in_read", 64'({Ready, RamEnable, RamWriteEnable, RamAddress, Count}),
        64'({1'b0, 1'b1, 1'b0, 8'h00, 9'd1}));
    Pop = 1'b0;
    #1;
    ResetN = 1'b0;
    #1;
    check_reset("reset_in_read");
    @(negedge Clk);
    ResetN = 1'b1;
    step(1'b1, 1'b0, 8'h5A);
    chk("push_after_reset", 64'({Ready, RamEnable, RamWriteEnable, RamAddress, RamDataIn, Count, Top}),
        64'({1'b0, 1'b1, 1'b1, 8'h00, 8'h5A, 9'd1, 8'h5A}));
    step(1'b0, 1'b0, 8'h00);
    chk("ram0_5a", 64'({mem[0], Count, Ready}), 64'({8'h5A, 9'd1, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_controller.md
# stack_controller

Sequences the single-port `RAMUnit` as a LIFO stack for the StackCircuit design. Accepts push and pop requests, maintains the stack pointer and drives all RAM control signals. Keeps the current top-of-stack in a register, so the top is readable without a RAM access. Sits between the user-facing button/switch logic and `RAMUnit`.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: width of a stack entry.
- `ADDR_WIDTH`, 8: RAM address width.
- `DEPTH`, 256: capacity in entries; must equal 2**ADDR_WIDTH.

**Ports** (name, direction, width, meaning)
- `Clk`, in, 1: single clock; all state changes on its rising edge.
- `ResetN`, in, 1: asynchronous, active-low reset.
- `Push`, in, 1: push request, sampled only when `Ready`.
- `Pop`, in, 1: pop request, sampled only when `Ready`.
- `DataIn`, in, DATA_WIDTH: value to push.
- `RamDataOut`, in, DATA_WIDTH: `RAMUnit` DataOut, registered with 1-cycle read latency.
- `RamEnable`, out, 1: to `RAMUnit`.
- `RamWriteEnable`, out, 1: to `RAMUnit`.
- `RamAddress`, out, ADDR_WIDTH: to `RAMUnit`.
- `RamDataIn`, out, DATA_WIDTH: to `RAMUnit`.
- `Top`, out, DATA_WIDTH: current top-of-stack.
- `TopValid`, out, 1: `Top` holds a live entry.
- `Count`, out, ADDR_WIDTH+1: number of entries, 0..DEPTH.
- `Empty`, out, 1: `Count`==0.
- `Full`, out, 1: `Count`==DEPTH.
- `Ready`, out, 1: controller is in IDLE and accepting requests.
- `Error`, out, 1: overflow/underflow indicator (see Configuration).

## Operation

**FSM states:** IDLE, WRITE, READ, CAPTURE.

**Outputs**
- `Ready` = (state==IDLE).
- RAM control signals are 0 in IDLE.
- `Empty` and `Full` are decoded from `Count`.

**Transitions from IDLE**
- **Push only, !Full:** `Top`<=`DataIn`, `TopValid`<=1, `Count`+1, go to WRITE.
- **Push only, Full:** ignored; overflow event.
- **Pop only, !Empty:**
  - `Count`-1.
  - If the new `Count`==0: `TopValid`<=0, stay in IDLE.
  - Otherwise go to READ.
- **Pop only, Empty:** ignored; underflow event.
- **Push and Pop, !Empty:** replace top. `Top`<=`DataIn`, `Count` unchanged, go to WRITE.
- **Push and Pop, Empty:** treated as a push only.

**Other states**
- **WRITE:** `RamEnable`=1, `RamWriteEnable`=1, `RamAddress`=`Count`-1, `RamDataIn`=`Top`. Go to IDLE.
- **READ:** `RamEnable`=1, `RamWriteEnable`=0, `RamAddress`=`Count`-1. Go to CAPTURE.
- **CAPTURE:** `RamEnable`=0, `Top`<=`RamDataOut`, `TopValid`<=1. Go to IDLE.

**Other rules**
- Requests while `Ready`=0 are dropped, not queued.
- Address arithmetic uses `Count`[ADDR_WIDTH-1:0]. The entry at address DEPTH-1 is written when `Count` goes DEPTH-1 → DEPTH; there is no wrap-around.

## Timing

**Reset values:** state=IDLE, `Count`=0, `Top`=0, `TopValid`=0, `Empty`=1, `Full`=0, `Ready`=1, `Error`=0, all RAM outputs 0.

**Latency**
- Push: `Top` and `Count` update on the accepting edge. `Ready` is low for 1 cycle (WRITE).
- Pop to non-empty: `Count` updates on the accepting edge. `Ready` is low for 2 cycles (READ, CAPTURE). `Top` is valid on the edge leaving CAPTURE.
- Pop to empty: 0 busy cycles.

**Reset mid-operation:** `ResetN` low in any state returns all outputs to their reset values immediately. An in-flight WRITE is lost. RAM contents are not cleared, but the stack is logically empty.

## Configuration

- **`STACK_ERROR_FLAG_EN` defined:** `Error` is set on any overflow or underflow event and stays set until reset.
- **`STACK_ERROR_FLAG_EN` undefined:** `Error` is tied to 0 and illegal requests are silently ignored. All other behaviour is identical.

## Structure

- **Package `stack_pkg`:**
  - State enum (IDLE, WRITE, READ, CAPTURE).
  - Default DATA_WIDTH/ADDR_WIDTH/DEPTH localparams.
- **Sub-module `stack_pointer`:**
  - Contains the `Count` register with inc/dec/hold controls.
  - Produces the `Empty`/`Full` decode.
  - Produces the `Count`-1 address.
- The FSM and `Top` register stay in `stack_controller`.

## Test plan

1. **Reset:** assert `ResetN`=0 mid-run → `Count`=0, `Empty`=1, `Full`=0, `Ready`=1, `TopValid`=0, `Error`=0, RAM outputs 0.
2. **Push sequence:** push 0x11, 0x22, 0x33 → `Top`=0x33, `Count`=3. RAM writes at addresses 0/1/2 with matching data. `Ready` is low exactly 1 cycle after each push.
3. **Pop sequence:** pop from test 2 → `Ready` low 2 cycles, then `Top`=0x22, `Count`=2. Two more pops → `Count`=0, `Empty`=1, `TopValid`=0, and the last pop takes 0 busy cycles.
4. **Overflow and underflow:**
   - Push 0..255 → `Full`=1, `Count`=256.
   - A further push of 0xAA is ignored and `Top` stays 0xFF. `Error`=1 with the macro defined, 0 without.
   - Pop when empty → `Count` stays 0, and `Error` follows the same macro rule.
5. **Replace top:** with `Count`=2 and `Top`=0x22, assert `Push`+`Pop` with `DataIn`=0x77 → `Top`=0x77, `Count`=2, RAM[1]=0x77.
6. **Reset during READ:** `ResetN`=0 while in READ → reset values on the next observation. A subsequent push of 0x5A writes RAM[0] and gives `Count`=1.
